slink_generic_fc_replay_nack: RTL
=================================

SLINK_GENERIC_FC_REPLAY_NACK -- requirements
Module: slink_generic_fc_replay_nack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of 2, 2..128.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), index width; all pointers are ADDR_WIDTH+1 bits (MSB = wrap bit).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, unacked-data timeout in link_clk cycles, 1..65535.
REQ-005 SHALL have port link_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port link_reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port enable  input  1  synchronous block enable, already in link_clk domain.
REQ-008 SHALL have ports a2l_valid input 1, a2l_ready output 1, a2l_data input DATA_WIDTH: application write handshake.
REQ-009 SHALL have ports link_ack_update input 1, link_ack_addr input ADDR_WIDTH+1: cumulative ack, pointer of first unacked entry.
REQ-010 SHALL have port link_nack  input  1  single-cycle replay request.
REQ-011 SHALL have ports link_valid output 1, link_data output DATA_WIDTH, link_cur_addr output ADDR_WIDTH+1, link_advance input 1: link read handshake.
REQ-012 SHALL have ports replay_active output 1 (state REPLAY) and ack_err output 1 (one-cycle pulse, rejected ack).

Function
REQ-013 SHALL keep four pointers: wr_ptr, ack_ptr, rd_ptr, sent_ptr; all increment modulo 2^(ADDR_WIDTH+1).
REQ-014 SHALL assert full when wr_ptr and ack_ptr differ in MSB and match in low ADDR_WIDTH bits; a2l_ready = enable & ~full.
REQ-015 SHALL write a2l_data into mem[wr_ptr] and increment wr_ptr on a2l_valid & a2l_ready; entry readable the next cycle.
REQ-016 SHALL drive link_valid = enable & (rd_ptr != wr_ptr); link_data = mem[rd_ptr low bits] combinationally, zero latency; link_cur_addr = rd_ptr.
REQ-017 SHALL increment rd_ptr on link_valid & link_advance; sent_ptr follows rd_ptr whenever state is RUN.
REQ-018 SHALL accept link_ack_update only when (link_ack_addr - ack_ptr) <= (sent_ptr - ack_ptr) modulo 2^(ADDR_WIDTH+1), loading ack_ptr; otherwise ignore it and pulse ack_err next cycle.
REQ-019 SHALL on link_nack (or timeout) load rd_ptr with ack_ptr, using the ack value accepted in the same cycle if any; nack overrides a same-cycle advance.
REQ-020 SHALL implement states IDLE, RUN, REPLAY: IDLE->RUN when enable; RUN->REPLAY on nack/timeout when new rd_ptr != sent_ptr; REPLAY->RUN when rd_ptr reaches sent_ptr; any state->IDLE when enable low.
REQ-021 SHALL in REPLAY not advance sent_ptr; a further nack in REPLAY rewinds rd_ptr to ack_ptr again and stays in REPLAY.
REQ-022 SHALL in IDLE hold a2l_ready, link_valid low and zero all pointers and the timeout counter the cycle after enable falls.
REQ-023 SHALL not overwrite any entry in [ack_ptr, wr_ptr) regardless of replay activity.

Reset
REQ-024 SHALL on link_reset_n low asynchronously clear all pointers, timeout counter, state (IDLE), ack_err; outputs a2l_ready, link_valid, replay_active, ack_err = 0, link_cur_addr = 0.
REQ-025 SHALL not reset memory contents; link_data is don't-care while link_valid = 0.

Configuration
REQ-026 SHALL with macro SLINK_FC_REPLAY_TIMEOUT_EN defined include a 16-bit counter: counts while ack_ptr != sent_ptr, clears on any accepted ack or nack, and at TIMEOUT_CYCLES acts as link_nack for one cycle then clears.
REQ-027 SHALL without SLINK_FC_REPLAY_TIMEOUT_EN omit the counter; replay only by link_nack; TIMEOUT_CYCLES unused.

Verification
REQ-028 SHALL cover fill: DEPTH=8, 8 writes, no ack -> a2l_ready=0 after 8th; ack addr 3 -> a2l_ready=1 next cycle, exactly 3 more writes accepted.
REQ-029 SHALL cover replay: send 5 entries, ack addr 2, nack -> replay_active=1, link_cur_addr=2, entries 2,3,4 re-sent in order, then RUN with sent_ptr=5.
REQ-030 SHALL cover simultaneous ack addr 4 + nack + advance at rd_ptr=6 -> ack_ptr=4, rd_ptr=4, advance ignored.
REQ-031 SHALL cover bad ack: sent_ptr=3, ack addr 6 -> ack_ptr unchanged, ack_err high one cycle.
REQ-032 SHALL cover wrap: 40 writes/reads/acks with DEPTH=8 -> data in order, pointer MSB toggles, no false full/empty.
REQ-033 SHALL cover timeout (macro on, TIMEOUT_CYCLES=16): send 2 entries, no ack -> rewind to ack_ptr 16 cycles after last ack/nack; enable drop mid-replay -> IDLE, pointers 0 next cycle.

Source files
------------

// File: rtl/slink_generic_fc_replay_nack.sv
// Link-layer replay buffer: holds application writes until they are acknowledged and rewinds the read pointer on nack.
// Optional macro SLINK_FC_REPLAY_TIMEOUT_EN adds an unacked-data timeout that behaves like a nack.
module slink_generic_fc_replay_nack #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 8,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  link_clk,
    input  logic                  link_reset_n,
    input  logic                  enable,
    input  logic                  a2l_valid,
    output logic                  a2l_ready,
    input  logic [DATA_WIDTH-1:0] a2l_data,
    input  logic                  link_ack_update,
    input  logic [ADDR_WIDTH:0]   link_ack_addr,
    input  logic                  link_nack,
    output logic                  link_valid,
    output logic [DATA_WIDTH-1:0] link_data,
    output logic [ADDR_WIDTH:0]   link_cur_addr,
    input  logic                  link_advance,
    output logic                  replay_active,
    output logic                  ack_err,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both high
    // (a2l: a2l_valid/a2l_ready; link: link_valid/link_advance). Valid never depends on ready.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPLAY = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   ack_ptr_q, ack_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   sent_ptr_q, sent_ptr_d;
    logic                  ack_err_q, ack_err_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  active;
    logic                  full;
    logic                  wr_fire;
    logic                  adv_fire;
    logic [ADDR_WIDTH:0]   ack_delta;
    logic [ADDR_WIDTH:0]   ack_span;
    logic                  ack_ok;
    logic [ADDR_WIDTH:0]   ack_new;
    logic                  tmo_fire;
    logic                  nack_eff;

    assign active        = (state_q != ST_IDLE);
    assign full          = (wr_ptr_q[ADDR_WIDTH] != ack_ptr_q[ADDR_WIDTH]) &&
                           (wr_ptr_q[ADDR_WIDTH-1:0] == ack_ptr_q[ADDR_WIDTH-1:0]);
    assign a2l_ready     = enable & active & ~full;
    assign link_valid    = enable & active & (rd_ptr_q != wr_ptr_q);
    assign link_data     = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign link_cur_addr = rd_ptr_q;
    assign replay_active = (state_q == ST_REPLAY);
    assign ack_err       = ack_err_q;
    assign dbg_state     = state_q;

    assign wr_fire  = a2l_valid & a2l_ready;
    assign adv_fire = link_valid & link_advance;

    // An ack may only move ack_ptr forward, and never past what has actually been sent.
    assign ack_delta = link_ack_addr - ack_ptr_q;
    assign ack_span  = sent_ptr_q - ack_ptr_q;
    assign ack_ok    = link_ack_update & (ack_delta <= ack_span);
    assign ack_new   = ack_ok ? link_ack_addr : ack_ptr_q;
    assign nack_eff  = link_nack | tmo_fire;

`ifdef SLINK_FC_REPLAY_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_fire = active & (tmo_cnt_q == TMO_LIMIT);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (!enable || !active) begin
            tmo_cnt_d = '0;
        end else if (ack_ok || nack_eff) begin
            tmo_cnt_d = '0;
        end else if (ack_ptr_q != sent_ptr_q) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge link_clk or negedge link_reset_n) begin
        if (!link_reset_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign tmo_fire       = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        ack_ptr_d  = ack_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sent_ptr_d = sent_ptr_q;
        ack_err_d  = 1'b0;
        if (!enable) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            ack_ptr_d  = '0;
            rd_ptr_d   = '0;
            sent_ptr_d = '0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            ack_ptr_d = ack_new;
            ack_err_d = link_ack_update & ~ack_ok;
            // A rewind wins over a same-cycle advance and uses the freshly accepted ack.
            if (nack_eff) begin
                rd_ptr_d = ack_new;
            end else if (adv_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if ((state_q == ST_RUN) && !nack_eff && adv_fire) begin
                sent_ptr_d = sent_ptr_q + 1'b1;
            end
            // Replaying exactly while the read pointer trails the high-water mark.
            state_d = (rd_ptr_d != sent_ptr_d) ? ST_REPLAY : ST_RUN;
        end
    end

    always_ff @(posedge link_clk or negedge link_reset_n) begin
        if (!link_reset_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            ack_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            sent_ptr_q <= '0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            ack_ptr_q  <= ack_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sent_ptr_q <= sent_ptr_d;
            ack_err_q  <= ack_err_d;
        end
    end

    // Storage is not reset; full protects every entry in [ack_ptr, wr_ptr).
    always_ff @(posedge link_clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= a2l_data;
        end
    end

endmodule
